uba_bus_resp: RTL and testbench
===============================

UBA_BUS_RESP -- requirements
Module: uba_bus_resp

Interface
REQ-001 Parameter: ubaNUM, 4'd1, IO controller number this UBA answers to.
REQ-002 Signal: clk  input  1  clock; all state changes on rising edge.
REQ-003 Signal: rst  input  1  reset; synchronous, active-high.
REQ-004 Signal: busREQI  input  1  backplane bus cycle request.
REQ-005 Signal: busADDRI  input  36 [0:35]  address and flags.
- bit 3 READ; bit 5 WRITE; bit 10 IO.
- bits 14:17 controller number; bits 18:35 register address.
REQ-006 Signal: busDATAI  input  36 [0:35]  bus write data (consumed by register blocks, not this block).
REQ-007 Signal: busACKO  output  1  cycle acknowledge.
REQ-008 Signal: busDATAO  output  36 [0:35]  read data.
REQ-009 Signal: pageADDR  output  6  page RAM index, from address bits 30:35.
REQ-010 Signal: pageDATA  input  36  page RAM read data, valid one cycle after pageADDR.
REQ-011 Signal: regUBASR  input  36  status register value.
REQ-012 Signal: regUBAMR  input  1  maintenance CR bit.
REQ-013 Signal: pageWRITE, statWRITE, maintWRITE  output  1 each  single-cycle register write strobes.

Function
REQ-014 The block SHALL decode a hit when all of the following hold:
- busREQI=1 and IO=1;
- READ or WRITE is set;
- bits 14:17 equal ubaNUM;
- address is 763000-763077 (page), 763100 (status) or 763101 (maint).
REQ-015 The FSM SHALL have exactly four states: IDLE, DECODE, RESP, HOLD.
REQ-016 IDLE SHALL go to DECODE on a hit, registering the target select, the read/write type and pageADDR; otherwise it stays in IDLE.
REQ-017 DECODE SHALL last exactly one cycle, go to RESP, and register the read mux output selected by the target.
REQ-018 RESP SHALL last exactly one cycle with busACKO=1, then go to HOLD.
- busACKO is asserted 2 cycles after the hit is sampled.
REQ-019 HOLD SHALL stay until busREQI=0, then go to IDLE; a request that is still asserted SHALL never be acknowledged twice.
REQ-020 On reads, busDATAO SHALL carry the selected data during RESP only and be all zero in every other state.
- page: pageDATA.
- status: regUBASR.
- maint: per REQ-029/030.
REQ-021 On writes (WRITE=1, READ=0), the matching strobe SHALL pulse high exactly during RESP, and busDATAO SHALL stay zero.
REQ-022 If READ and WRITE are both set, the cycle SHALL be treated as a read with no write strobe.
REQ-023 A non-matching address or controller number SHALL produce no busACKO and no strobe; the bus timeout is handled elsewhere.
REQ-024 If busREQI drops in DECODE, the FSM SHALL return to IDLE next cycle with no busACKO and no strobe.
REQ-025 At most one strobe SHALL be high in any cycle.

Reset
REQ-026 While rst=1, the FSM SHALL enter IDLE, and busACKO, busDATAO, all strobes and pageADDR SHALL be 0.
REQ-027 Reset in any state SHALL abort the cycle, with no strobe in the following cycle.
REQ-028 After rst falls, a hit SHALL be recognised on the first sampled cycle.

Configuration
REQ-029 With UBA_MR_READBACK_EN defined, a maint read SHALL return regUBAMR in bit 35 and zeros elsewhere.
REQ-030 Without UBA_MR_READBACK_EN, a maint read SHALL return all zeros; decode, ack and write behaviour are identical in both builds.

Verification
REQ-031 Page read: ubaNUM=1, READ|IO, address 1,763005, pageDATA=0o123456701234.
- Required: pageADDR=5; busACKO high in cycle 2 only; busDATAO=0o123456701234 in cycle 2 only.
REQ-032 Maint write: WRITE|IO, address 1,763101, busREQI held high 6 cycles.
- Required: maintWRITE and busACKO high in cycle 2 only; no second ack while the FSM is in HOLD.
REQ-033 Miss: address 3,763100 with ubaNUM=1.
- Required: busACKO=0 and all strobes 0 for 10 cycles.
REQ-034 Maint read with regUBAMR=1.
- With the macro: busDATAO=0o000000000001.
- Without the macro: busDATAO=0.
REQ-035 Abort cases, status write:
- busREQI dropped in DECODE: no statWRITE, no busACKO, FSM back in IDLE.
- rst asserted in DECODE: no statWRITE, no busACKO, FSM back in IDLE.

Source files
------------

// File: rtl/uba_bus_resp.sv
// UBA backplane bus responder: decodes IO cycles aimed at this controller's
// page RAM, status and maintenance registers and answers them with a fixed
// IDLE -> DECODE -> RESP -> HOLD handshake.
// Bus bit n (bit 0 = MSB) is held at vector index 35-n, so the vectors are
// declared descending: READ=[32], WRITE=[30], IO=[25], controller=[21:18],
// register address=[17:0], page index=[5:0].
// Optional build macro: UBA_MR_READBACK_EN (maint read returns regUBAMR in bit 35).
module uba_bus_resp #(
  parameter logic [3:0] ubaNUM = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busREQI,
  input  logic [35:0] busADDRI,
  input  logic [35:0] busDATAI,
  output logic        busACKO,
  output logic [35:0] busDATAO,
  output logic [5:0]  pageADDR,
  input  logic [35:0] pageDATA,
  input  logic [35:0] regUBASR,
  input  logic        regUBAMR,
  output logic        pageWRITE,
  output logic        statWRITE,
  output logic        maintWRITE
);

  localparam int unsigned DW = 36;
  localparam int unsigned RW = 18;
  localparam int unsigned PW = 6;

  localparam logic [RW-1:0] STAT_ADDR  = 18'o763100;
  localparam logic [RW-1:0] MAINT_ADDR = 18'o763101;
  localparam logic [11:0]   PAGE_BASE  = 12'o7630;

  typedef enum logic [1:0] {IDLE, DECODE, RESP, HOLD} state_t;
  typedef enum logic [1:0] {SEL_PAGE, SEL_STAT, SEL_MAINT} sel_t;

  state_t         state_q, state_n;
  sel_t           sel_q, sel_n, sel_c;
  logic           rd_q, rd_n;
  logic           wr_q, wr_n;
  logic [PW-1:0]  page_addr_n;
  logic           ack_n;
  logic [DW-1:0]  data_n;
  logic           page_wr_n, stat_wr_n, maint_wr_n;

  logic           flag_rd_c, flag_wr_c, flag_io_c;
  logic [3:0]     ctl_c;
  logic [RW-1:0]  reg_addr_c;
  logic           page_hit_c, stat_hit_c, maint_hit_c, hit_c;
  logic [DW-1:0]  mr_data_c;
  logic           unused_inputs;

  assign flag_rd_c  = busADDRI[32];
  assign flag_wr_c  = busADDRI[30];
  assign flag_io_c  = busADDRI[25];
  assign ctl_c      = busADDRI[21:18];
  assign reg_addr_c = busADDRI[RW-1:0];

  // Address decode for the three register windows
  assign page_hit_c  = (reg_addr_c[RW-1:6] == PAGE_BASE);
  assign stat_hit_c  = (reg_addr_c == STAT_ADDR);
  assign maint_hit_c = (reg_addr_c == MAINT_ADDR);
  assign hit_c = busREQI && flag_io_c && (flag_rd_c || flag_wr_c) &&
                 (ctl_c == ubaNUM) && (page_hit_c || stat_hit_c || maint_hit_c);

  // Target select for a decoded hit
  always_comb begin
    sel_c = SEL_PAGE;
    if (stat_hit_c)       sel_c = SEL_STAT;
    else if (maint_hit_c) sel_c = SEL_MAINT;
  end

`ifdef UBA_MR_READBACK_EN
  assign mr_data_c = {35'b0, regUBAMR};
`else
  assign mr_data_c = '0;
`endif

  // Write data and unused flag bits are consumed by the register blocks
  assign unused_inputs = ^{busDATAI, busADDRI, regUBAMR};

  // Next-state and next-output logic
  always_comb begin
    state_n     = state_q;
    sel_n       = sel_q;
    rd_n        = rd_q;
    wr_n        = wr_q;
    page_addr_n = pageADDR;
    ack_n       = 1'b0;
    data_n      = '0;
    page_wr_n   = 1'b0;
    stat_wr_n   = 1'b0;
    maint_wr_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_c) begin
          state_n     = DECODE;
          sel_n       = sel_c;
          rd_n        = flag_rd_c;
          wr_n        = flag_wr_c && !flag_rd_c;
          page_addr_n = busADDRI[PW-1:0];
        end
      end
      DECODE: begin
        if (!busREQI) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
          ack_n   = 1'b1;
          if (rd_q) begin
            case (sel_q)
              SEL_PAGE:  data_n = pageDATA;
              SEL_STAT:  data_n = regUBASR;
              SEL_MAINT: data_n = mr_data_c;
              default:   data_n = '0;
            endcase
          end else if (wr_q) begin
            case (sel_q)
              SEL_PAGE:  page_wr_n  = 1'b1;
              SEL_STAT:  stat_wr_n  = 1'b1;
              SEL_MAINT: maint_wr_n = 1'b1;
              default:   ;
            endcase
          end
        end
      end
      RESP: state_n = HOLD;
      HOLD: begin
        if (!busREQI) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= SEL_PAGE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      pageADDR   <= '0;
      busACKO    <= 1'b0;
      busDATAO   <= '0;
      pageWRITE  <= 1'b0;
      statWRITE  <= 1'b0;
      maintWRITE <= 1'b0;
    end else begin
      state_q    <= state_n;
      sel_q      <= sel_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      pageADDR   <= page_addr_n;
      busACKO    <= ack_n;
      busDATAO   <= data_n;
      pageWRITE  <= page_wr_n;
      statWRITE  <= stat_wr_n;
      maintWRITE <= maint_wr_n;
    end
  end

endmodule

// File: tb/tb_uba_bus_resp.sv
// Directed bench for uba_bus_resp: reads, writes, misses, aborts and reset.
module tb_uba_bus_resp;

  localparam logic [35:0] F_RD = 36'h1_0000_0000;
  localparam logic [35:0] F_WR = 36'h0_4000_0000;
  localparam logic [35:0] F_IO = 36'h0_0200_0000;
  localparam logic [35:0] PDATA = 36'o123456701234;
  localparam logic [35:0] SRDATA = 36'o765432101234;
`ifdef UBA_MR_READBACK_EN
  localparam logic [35:0] MR_EXP = 36'o000000000001;
`else
  localparam logic [35:0] MR_EXP = 36'o000000000000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        busREQI;
  logic [35:0] busADDRI;
  logic [35:0] busDATAI;
  logic        busACKO;
  logic [35:0] busDATAO;
  logic [5:0]  pageADDR;
  logic [35:0] pageDATA;
  logic [35:0] regUBASR;
  logic        regUBAMR;
  logic        pageWRITE, statWRITE, maintWRITE;

  int checks = 0;
  int errors = 0;

  uba_bus_resp #(.ubaNUM(4'd1)) dut (
    .clk(clk), .rst(rst), .busREQI(busREQI), .busADDRI(busADDRI),
    .busDATAI(busDATAI), .busACKO(busACKO), .busDATAO(busDATAO),
    .pageADDR(pageADDR), .pageDATA(pageDATA), .regUBASR(regUBASR),
    .regUBAMR(regUBAMR), .pageWRITE(pageWRITE), .statWRITE(statWRITE),
    .maintWRITE(maintWRITE)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] mk(input logic [3:0] ctl, input logic [17:0] ra);
    return (36'(ctl) << 18) | 36'(ra);
  endfunction

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
    end
  endtask

  // One transaction; cycle 0 is the cycle whose closing edge samples the request
  task automatic run_txn(input string tag, input logic [35:0] addr, input int ncyc,
                         input int req_len, input int rst_cyc, input int ack_cyc,
                         input logic [35:0] exp_data, input logic [2:0] exp_strb,
                         input int exp_pa);
    for (int c = 0; c < ncyc; c++) begin
      busADDRI = addr;
      busREQI  = (c < req_len);
      rst      = (c == rst_cyc);
      #1;
      check($sformatf("%s c%0d ack", tag, c), 36'(busACKO), 36'(c == ack_cyc));
      check($sformatf("%s c%0d data", tag, c), busDATAO,
            (c == ack_cyc) ? exp_data : 36'd0);
      check($sformatf("%s c%0d strb", tag, c), 36'({pageWRITE, statWRITE, maintWRITE}),
            (c == ack_cyc) ? 36'(exp_strb) : 36'd0);
      if (c == 1 && exp_pa >= 0)
        check($sformatf("%s pageADDR", tag), 36'(pageADDR), 36'(exp_pa));
      @(negedge clk);
    end
    busREQI = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    busREQI  = 1'b1;
    busADDRI = F_RD | F_IO | mk(4'd1, 18'o763005);
    busDATAI = 36'o111111111111;
    pageDATA = PDATA;
    regUBASR = SRDATA;
    regUBAMR = 1'b1;

    // Reset held with a live hit on the bus: everything stays quiet
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("reset%0d ack", i), 36'(busACKO), 36'd0);
      check($sformatf("reset%0d data", i), busDATAO, 36'd0);
      check($sformatf("reset%0d strb", i), 36'({pageWRITE, statWRITE, maintWRITE}), 36'd0);
      check($sformatf("reset%0d pa", i), 36'(pageADDR), 36'd0);
    end
    @(negedge clk);

    // Page read right out of reset
    run_txn("page_rd", F_RD | F_IO | mk(4'd1, 18'o763005), 7, 5, -1, 2, PDATA, 3'b000, 5);
    // Maint write held for 6 cycles: single ack
    run_txn("maint_wr", F_WR | F_IO | mk(4'd1, 18'o763101), 8, 6, -1, 2, 36'd0, 3'b001, 1);
    // Misses
    run_txn("miss_ctl", F_RD | F_IO | mk(4'd3, 18'o763100), 10, 10, -1, -1, 36'd0, 3'b000, -1);
    run_txn("miss_noio", F_RD | mk(4'd1, 18'o763100), 4, 4, -1, -1, 36'd0, 3'b000, -1);
    run_txn("miss_norw", F_IO | mk(4'd1, 18'o763100), 4, 4, -1, -1, 36'd0, 3'b000, -1);
    run_txn("miss_lo", F_RD | F_IO | mk(4'd1, 18'o762777), 4, 4, -1, -1, 36'd0, 3'b000, -1);
    run_txn("miss_hi", F_WR | F_IO | mk(4'd1, 18'o763102), 4, 4, -1, -1, 36'd0, 3'b000, -1);
    // Status read and page write at the top of the page window
    run_txn("stat_rd", F_RD | F_IO | mk(4'd1, 18'o763100), 5, 3, -1, 2, SRDATA, 3'b000, 0);
    run_txn("page_wr", F_WR | F_IO | mk(4'd1, 18'o763077), 5, 3, -1, 2, 36'd0, 3'b100, 63);
    // READ and WRITE together behave as a read
    run_txn("rdwr", F_RD | F_WR | F_IO | mk(4'd1, 18'o763100), 5, 3, -1, 2, SRDATA, 3'b000, 0);
    // Maint read
    run_txn("maint_rd", F_RD | F_IO | mk(4'd1, 18'o763101), 5, 3, -1, 2, MR_EXP, 3'b000, 1);
    // Request dropped in DECODE, then a clean cycle proves the FSM is idle
    run_txn("abort_req", F_WR | F_IO | mk(4'd1, 18'o763100), 4, 1, -1, -1, 36'd0, 3'b000, 0);
    run_txn("after_req", F_WR | F_IO | mk(4'd1, 18'o763100), 5, 3, -1, 2, 36'd0, 3'b010, 0);
    // Reset in DECODE, then a clean cycle
    run_txn("abort_rst", F_WR | F_IO | mk(4'd1, 18'o763100), 5, 2, 1, -1, 36'd0, 3'b000, 0);
    run_txn("after_rst", F_WR | F_IO | mk(4'd1, 18'o763100), 5, 3, -1, 2, 36'd0, 3'b010, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
